// File: rtl/csa_share_arbiter.sv
// Two-requester round-robin front end for one shared external carry-skip adder, one operation in flight.
// Optional per-requester saturating grant counters are enabled by defining CSA_ARB_STATS_EN.
module csa_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_rr_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_acc0;
  logic             w_acc1;

  // Tie goes to the requester that was not granted last; readys are forced low while in reset.
  always_comb begin
    w_next_state = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst) begin
          if (req0_valid && (!req1_valid || r_rr_last)) req0_ready = 1'b1;
          else if (req1_valid)                         req1_ready = 1'b1;
        end
        if (req0_ready || req1_ready) w_next_state = S_ADD;
      end
      S_ADD:   w_next_state = S_RESP;
      S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_acc0 = req0_valid & req0_ready;
  assign w_acc1 = req1_valid & req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_last <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
      r_id      <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_acc0) begin
        r_a       <= req0_a;
        r_b       <= req0_b;
        r_cin     <= req0_cin;
        r_id      <= 1'b0;
        r_rr_last <= 1'b0;
      end else if (w_acc1) begin
        r_a       <= req1_a;
        r_b       <= req1_b;
        r_cin     <= req1_cin;
        r_id      <= 1'b1;
        r_rr_last <= 1'b1;
      end
      if (r_state == S_ADD) begin
        r_sum  <= add_sum;
        r_cout <= add_cout;
      end
    end
  end

  // The adder sees only the operand registers, so its inputs cannot glitch with requester traffic.
  assign add_a     = r_a;
  assign add_b     = r_b;
  assign add_cin   = r_cin;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;

`ifdef CSA_ARB_STATS_EN
  logic [7:0] r_cnt0;
  logic [7:0] r_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= 8'd0;
      r_cnt1 <= 8'd0;
    end else begin
      if (w_acc0 && (r_cnt0 != 8'hFF)) r_cnt0 <= r_cnt0 + 8'd1;
      if (w_acc1 && (r_cnt1 != 8'hFF)) r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`else
  assign grant_cnt0 = 8'd0;
  assign grant_cnt1 = 8'd0;
`endif

endmodule

// File: tb/tb_csa_share_arbiter.sv
// Directed bench for csa_share_arbiter; supplies the external adder as a combinational model.
module tb_csa_share_arbiter;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             req0_valid, req0_ready, req0_cin;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_cin;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [WIDTH-1:0] add_a, add_b, add_sum, rsp_sum;
  logic             add_cin, add_cout;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [7:0]       grant_cnt0, grant_cnt1;

  int n_checks = 0;
  int n_errors = 0;

  csa_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic       exp_id [4];
  logic [7:0] exp_sum[4];
  logic       exp_co [4];
  int         miss;
  logic [7:0] exp_cnt0;

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_cin = 1'b0;
    @(negedge clk);
    tick();
    check("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_add_a", {24'd0, add_a}, 32'h00);
    check("rst_add_cin", {31'd0, add_cin}, 32'd0);
    check("rst_rsp_sum", {24'd0, rsp_sum}, 32'h00);
    check("rst_cnt0", {24'd0, grant_cnt0}, 32'd0);
    tick();

    // First op: 0x7F + 0x01 from requester 0, valid held
    rst = 1'b0; rsp_ready = 1'b1;
    req0_a = 8'h7F; req0_b = 8'h01; req0_cin = 1'b0;
    #1;
    check("op1_rdy0", {31'd0, req0_ready}, 32'd1);
    check("op1_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    check("op1_add_rdy0", {31'd0, req0_ready}, 32'd0);
    check("op1_add_vld", {31'd0, rsp_valid}, 32'd0);
    check("op1_add_a", {24'd0, add_a}, 32'h7F);
    check("op1_add_b", {24'd0, add_b}, 32'h01);
    tick();
    check("op1_rsp_vld", {31'd0, rsp_valid}, 32'd1);
    check("op1_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("op1_rsp_sum", {24'd0, rsp_sum}, 32'h80);
    check("op1_rsp_cout", {31'd0, rsp_cout}, 32'd0);
    tick();
    check("op1_idle_vld", {31'd0, rsp_valid}, 32'd0);
    check("op1_idle_rdy0", {31'd0, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    #1;
    check("drop_rdy0", {31'd0, req0_ready}, 32'd0);

    // Carry boundary from requester 1
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h00; req1_cin = 1'b1;
    #1;
    check("op2_rdy1", {31'd0, req1_ready}, 32'd1);
    check("op2_rdy0", {31'd0, req0_ready}, 32'd0);
    tick();
    req1_valid = 1'b0;
    check("op2_add_a", {24'd0, add_a}, 32'hFF);
    check("op2_add_cin", {31'd0, add_cin}, 32'd1);
    tick();
    check("op2_rsp_vld", {31'd0, rsp_valid}, 32'd1);
    check("op2_rsp_id", {31'd0, rsp_id}, 32'd1);
    check("op2_rsp_sum", {24'd0, rsp_sum}, 32'h00);
    check("op2_rsp_cout", {31'd0, rsp_cout}, 32'd1);
    tick();

    // Both valid continuously: 0x10+0x20=0x30 for req0, 0x80+0x80=0x100 for req1
    exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_sum = '{8'h30, 8'h00, 8'h30, 8'h00};
    exp_co  = '{1'b0, 1'b1, 1'b0, 1'b1};
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h80; req1_cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d_rdy0", i), {31'd0, req0_ready}, {31'd0, exp_id[i] == 1'b0});
      check($sformatf("rr%0d_rdy1", i), {31'd0, req1_ready}, {31'd0, exp_id[i] == 1'b1});
      tick();
      tick();
      check($sformatf("rr%0d_vld", i), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("rr%0d_id", i), {31'd0, rsp_id}, {31'd0, exp_id[i]});
      check($sformatf("rr%0d_sum", i), {24'd0, rsp_sum}, {24'd0, exp_sum[i]});
      check($sformatf("rr%0d_cout", i), {31'd0, rsp_cout}, {31'd0, exp_co[i]});
      tick();
    end

    // Response stall: 0x3C+0x0F+1 = 0x4C, both requesters still asking
    req0_a = 8'h3C; req0_b = 8'h0F; req0_cin = 1'b1;
    rsp_ready = 1'b0;
    #1;
    check("stall_rdy0", {31'd0, req0_ready}, 32'd1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_vld", i), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("stall%0d_id", i), {31'd0, rsp_id}, 32'd0);
      check($sformatf("stall%0d_sum", i), {24'd0, rsp_sum}, 32'h4C);
      check($sformatf("stall%0d_cout", i), {31'd0, rsp_cout}, 32'd0);
      check($sformatf("stall%0d_rdys", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("stall_hs_vld", {31'd0, rsp_valid}, 32'd1);
    check("stall_hs_rdys", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    #1;
    check("post_stall_rdy1", {31'd0, req1_ready}, 32'd1);
    check("post_stall_rdy0", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset during ADD after a requester-0 grant
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_cin = 1'b0;
    #1;
    check("abort_rdy0", {31'd0, req0_ready}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    check("abort_rst_rdy0", {31'd0, req0_ready}, 32'd0);
    tick();
    rst = 1'b0; req0_valid = 1'b0;
    #1;
    check("abort_vld0", {31'd0, rsp_valid}, 32'd0);
    check("abort_add_a", {24'd0, add_a}, 32'h00);
    check("abort_cnt0", {24'd0, grant_cnt0}, 32'd0);
    tick();
    check("abort_vld1", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("abort_vld2", {31'd0, rsp_valid}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00;
    #1;
    check("abort_tie_rdy0", {31'd0, req0_ready}, 32'd1);
    check("abort_tie_rdy1", {31'd0, req1_ready}, 32'd0);
    req1_valid = 1'b0;

    // 300 back-to-back requester-0 operations
    miss = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (!req0_ready) miss++;
      tick();
      tick();
      tick();
    end
    req0_valid = 1'b0;
    check("sat_accepts_missed", miss, 32'd0);
`ifdef CSA_ARB_STATS_EN
    exp_cnt0 = 8'd255;
`else
    exp_cnt0 = 8'd0;
`endif
    check("sat_cnt0", {24'd0, grant_cnt0}, {24'd0, exp_cnt0});
    check("sat_cnt1", {24'd0, grant_cnt1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
